reg_file_dual_wr: RTL and testbench
===================================

Name: reg_file_dual_wr

Overview:
Parametrised multi-port register file for the datapath. It is the successor to the fixed 8x16 single-write register file. It provides two combinational read ports with write-to-read bypass and two write ports with deterministic priority. A sequential clear engine zeroes the array after reset or on request, and per-register dirty flags support load/store tracking in the control unit.

Parameters:
DATA_W, 16, width of each register
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, if 1 register 0 is hardwired to zero (reads 0, writes dropped, never dirty)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
clr_req  in  1  request full-array clear (sampled only when ready=1)
ready  out  1  1 = array usable; 0 during clear sweep
rd_addr1  in  ADDR_W  read port 1 address
rd_data1  out  DATA_W  read port 1 data (combinational)
rd_addr2  in  ADDR_W  read port 2 address
rd_data2  out  DATA_W  read port 2 data (combinational)
wa_en  in  1  write port A enable
wa_addr  in  ADDR_W  write port A address
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable (priority port)
wb_addr  in  ADDR_W  write port B address
wb_data  in  DATA_W  write port B data
wr_conflict  out  1  registered pulse: A and B wrote the same address last cycle
dirty  out  DEPTH  bit i set once register i has been written since the last clear

Behaviour:
- The clock is clk. Reset is rst_n: synchronous, active-low, sampled on the rising clk edge.
- FSM states: CLEAR and READY.
- Reset (rst_n=0 at an edge):
  - state<=CLEAR, clr_addr<=0.
  - ready=0, dirty=0, wr_conflict=0.
  - Array contents are not touched while rst_n is held low.
- CLEAR, each edge with rst_n=1:
  - registers[clr_addr]<=0, clr_addr<=clr_addr+1.
  - When clr_addr==DEPTH-1, that write completes and state<=READY.
  - ready rises exactly DEPTH edges after the first edge with rst_n=1.
- In CLEAR, write enables are ignored, clr_req is ignored, rd_data1/2 read 0, and dirty stays 0.
- READY, clr_req=1 at an edge:
  - Writes presented in that same cycle are still performed.
  - Next state is CLEAR, clr_addr<=0, dirty<=0.
- Writes (READY only), on the rising edge:
  - wa_en writes wa_data to wa_addr; wb_en writes wb_data to wb_addr.
  - Different addresses: both are performed.
  - Same address with both enabled: B's data is stored, and wr_conflict=1 for the following cycle only.
  - dirty[addr] is set for every performed write.
- Reads (combinational):
  - In READY with no write match, rd_dataN = registers[rd_addrN].
  - Bypass: if wb_en && wb_addr==rd_addrN, output wb_data. Otherwise, if wa_en && wa_addr==rd_addrN, output wa_data.
  - Bypass applies only in READY.
- ZERO_REG=1: address 0 always reads 0 (bypass included), writes to address 0 are dropped, dirty[0] stays 0, and wr_conflict is still flagged for a same-address-0 collision.
- Reset mid-clear: the sweep restarts from address 0 after rst_n is released.
- Reset mid-write: the write is dropped, because reset has priority over all updates.
- clr_addr wraps naturally. It is never observable outside CLEAR.
- Arithmetic: none on data. clr_addr is ADDR_W bits wide.

Test Plan:
- Reset and sweep: hold rst_n=0 for 3 cycles, then release with DEPTH=8 -> ready=0 for exactly 8 edges, then 1. All reads return 0 and dirty=8'h00.
- Dual write: wa writes 16'h1234 to addr 2 and wb writes 16'hABCD to addr 5 in one cycle -> next cycle rd_addr1=2 gives 16'h1234, rd_addr2=5 gives 16'hABCD, dirty=8'h24, wr_conflict=0.
- Conflict plus bypass:
  - Stimulus: wa and wb both write addr 3 (wa 16'h1111, wb 16'h2222) with rd_addr1=3.
  - Same cycle: rd_data1=16'h2222.
  - Next cycle: rd_data1=16'h2222 from the array, and wr_conflict=1 for one cycle only.
- Clear request: with addr 4=16'h00FF, assert clr_req for 1 cycle while wa writes 16'h0F0F to addr 6 -> ready low for 8 cycles; afterwards addrs 4 and 6 read 0 and dirty=0. Writes issued during the sweep are lost.
- ZERO_REG=1: write 16'hFFFF to addr 0 -> rd_data1 at addr 0 reads 0 in the write cycle and after it, and dirty[0]=0.
- Reset mid-sweep: assert rst_n=0 at sweep step 4, then release -> ready asserts 8 edges after release, not 4.

Source files
------------

// File: rtl/reg_file_dual_wr.sv
// Parametrised register file with two combinational read ports and two write
// ports. Port B wins a same-address collision. A clear sweep zeroes the array
// one entry per cycle after reset or on request. Per-entry dirty flags record
// which registers have been written since the last clear.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | sweeping clr_addr through the array, writes/reads blocked
// ST_READY | normal operation, writes and bypassed reads active
module reg_file_dual_wr #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clr_req_i,
    output logic                   ready_o,
    input  logic [ADDR_W-1:0]      rd_addr1_i,
    output logic [DATA_W-1:0]      rd_data1_o,
    input  logic [ADDR_W-1:0]      rd_addr2_i,
    output logic [DATA_W-1:0]      rd_data2_o,
    input  logic                   wa_en_i,
    input  logic [ADDR_W-1:0]      wa_addr_i,
    input  logic [DATA_W-1:0]      wa_data_i,
    input  logic                   wb_en_i,
    input  logic [ADDR_W-1:0]      wb_addr_i,
    input  logic [DATA_W-1:0]      wb_data_i,
    output logic                   wr_conflict_o,
    output logic [2**ADDR_W-1:0]   dirty_o
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic              HAS_ZERO  = (ZERO_REG != 0);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [DEPTH-1:0]    dirty_q, dirty_d;
    logic                conflict_q, conflict_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic is_ready;
    logic wa_ok;
    logic wb_ok;

    // A write to the hardwired zero register is dropped but still counts
    // toward collision detection.
    assign is_ready = (state_q == ST_READY);
    assign wa_ok    = is_ready && wa_en_i && !(HAS_ZERO && (wa_addr_i == '0));
    assign wb_ok    = is_ready && wb_en_i && !(HAS_ZERO && (wb_addr_i == '0));

    // Control registers; reset forces a fresh sweep from address 0.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            dirty_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            dirty_q    <= dirty_d;
            conflict_q <= conflict_d;
        end
    end

    // Next-state: sweep sequencing, dirty tracking and collision detect.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        dirty_d    = dirty_q;
        conflict_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                conflict_d = wa_en_i && wb_en_i && (wa_addr_i == wb_addr_i);
                if (wa_ok) dirty_d[wa_addr_i] = 1'b1;
                if (wb_ok) dirty_d[wb_addr_i] = 1'b1;
                // Clear request wins over same-cycle dirty updates; the
                // data writes themselves still land before the sweep.
                if (clr_req_i) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                    dirty_d    = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Array storage: sweep zeroing, or A then B so B overrides on collision.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_addr_q] <= '0;
            end else begin
                if (wa_ok) mem_q[wa_addr_i] <= wa_data_i;
                if (wb_ok) mem_q[wb_addr_i] <= wb_data_i;
            end
        end
    end

    function automatic logic [DATA_W-1:0] rd_sel(
        input logic              rdy,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored
    );
        if (!rdy)                                   return '0;
        if (HAS_ZERO && (addr == '0))               return '0;
        if (wb_en_i && (wb_addr_i == addr))         return wb_data_i;
        if (wa_en_i && (wa_addr_i == addr))         return wa_data_i;
        return stored;
    endfunction

    // Combinational read ports with write-to-read bypass.
    always_comb begin
        rd_data1_o = rd_sel(is_ready, rd_addr1_i, mem_q[rd_addr1_i]);
        rd_data2_o = rd_sel(is_ready, rd_addr2_i, mem_q[rd_addr2_i]);
    end

    assign ready_o       = is_ready;
    assign wr_conflict_o = conflict_q;
    assign dirty_o       = dirty_q;

endmodule

// File: tb/tb_reg_file_dual_wr.sv
// Directed bench for reg_file_dual_wr: one default instance and one with the
// hardwired zero register, both driven by the same stimulus.
module tb_reg_file_dual_wr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_req;
    logic [2:0]  rd_addr1, rd_addr2;
    logic        wa_en, wb_en;
    logic [2:0]  wa_addr, wb_addr;
    logic [15:0] wa_data, wb_data;

    logic        ready, wr_conflict;
    logic [15:0] rd_data1, rd_data2;
    logic [7:0]  dirty;

    logic        z_ready, z_wr_conflict;
    logic [15:0] z_rd_data1, z_rd_data2;
    logic [7:0]  z_dirty;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    reg_file_dual_wr #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clr_req_i(clr_req), .ready_o(ready),
        .rd_addr1_i(rd_addr1), .rd_data1_o(rd_data1),
        .rd_addr2_i(rd_addr2), .rd_data2_o(rd_data2),
        .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .wr_conflict_o(wr_conflict), .dirty_o(dirty)
    );

    reg_file_dual_wr #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_z (
        .clk_i(clk), .rst_n_i(rst_n), .clr_req_i(clr_req), .ready_o(z_ready),
        .rd_addr1_i(rd_addr1), .rd_data1_o(z_rd_data1),
        .rd_addr2_i(rd_addr2), .rd_data2_o(z_rd_data2),
        .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .wr_conflict_o(z_wr_conflict), .dirty_o(z_dirty)
    );

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes;
        wa_en = 1'b0; wb_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; idle_writes();
        rd_addr1 = '0; rd_addr2 = '0;
        wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
        repeat (3) tick();
        tests_run++;
        if (ready !== 1'b0 || dirty !== 8'h00 || wr_conflict !== 1'b0 || z_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b dirty=%h conflict=%b z_ready=%b, want 0 00 0 0",
                     ready, dirty, wr_conflict, z_ready);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            tests_run++;
            if (ready !== (i == 8) || z_ready !== (i == 8)) begin
                tests_failed++;
                $display("FAIL sweep_ready edge %0d: ready=%b z_ready=%b, want %b", i, ready, z_ready, i == 8);
            end
        end
        for (int a = 0; a < 8; a++) begin
            rd_addr1 = 3'(a); rd_addr2 = 3'(7 - a);
            #1;
            tests_run++;
            if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
                tests_failed++;
                $display("FAIL sweep_zero addr %0d: rd1=%h rd2=%h, want 0000 0000", a, rd_data1, rd_data2);
            end
        end
        tests_run++;
        if (dirty !== 8'h00) begin
            tests_failed++;
            $display("FAIL sweep_dirty: got %h want 00", dirty);
        end
    endtask

    task automatic test_dual_write;
        wa_en = 1'b1; wa_addr = 3'd2; wa_data = 16'h1234;
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'hABCD;
        tick();
        idle_writes();
        rd_addr1 = 3'd2; rd_addr2 = 3'd5;
        #1;
        tests_run++;
        if (rd_data1 !== 16'h1234 || rd_data2 !== 16'hABCD) begin
            tests_failed++;
            $display("FAIL dual_write_data: rd1=%h rd2=%h, want 1234 abcd", rd_data1, rd_data2);
        end
        tests_run++;
        if (dirty !== 8'h24 || wr_conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL dual_write_flags: dirty=%h conflict=%b, want 24 0", dirty, wr_conflict);
        end
        // Port A bypass alone; port 2 reads an unrelated stored value.
        wa_en = 1'b1; wa_addr = 3'd2; wa_data = 16'h5555;
        #1;
        tests_run++;
        if (rd_data1 !== 16'h5555 || rd_data2 !== 16'hABCD) begin
            tests_failed++;
            $display("FAIL bypass_a: rd1=%h rd2=%h, want 5555 abcd", rd_data1, rd_data2);
        end
        tick();
        idle_writes();
        #1;
        tests_run++;
        if (rd_data1 !== 16'h5555) begin
            tests_failed++;
            $display("FAIL bypass_a_stored: rd1=%h want 5555", rd_data1);
        end
    endtask

    task automatic test_conflict;
        wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'h1111;
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h2222;
        rd_addr1 = 3'd3;
        #1;
        tests_run++;
        if (rd_data1 !== 16'h2222) begin
            tests_failed++;
            $display("FAIL conflict_bypass: rd1=%h want 2222", rd_data1);
        end
        tick();
        idle_writes();
        #1;
        tests_run++;
        if (rd_data1 !== 16'h2222 || wr_conflict !== 1'b1 || dirty !== 8'h2C) begin
            tests_failed++;
            $display("FAIL conflict_stored: rd1=%h conflict=%b dirty=%h, want 2222 1 2c",
                     rd_data1, wr_conflict, dirty);
        end
        tick();
        tests_run++;
        if (wr_conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL conflict_pulse: conflict=%b want 0", wr_conflict);
        end
    endtask

    task automatic test_clear_req;
        wa_en = 1'b1; wa_addr = 3'd4; wa_data = 16'h00FF;
        tick();
        idle_writes();
        rd_addr1 = 3'd4;
        #1;
        tests_run++;
        if (rd_data1 !== 16'h00FF) begin
            tests_failed++;
            $display("FAIL clear_pre: rd1=%h want 00ff", rd_data1);
        end
        clr_req = 1'b1;
        wa_en = 1'b1; wa_addr = 3'd6; wa_data = 16'h0F0F;
        tick();
        clr_req = 1'b0;
        // Writes during the sweep must be ignored, and so must their bypass.
        wa_en = 1'b1; wa_addr = 3'd1; wa_data = 16'h7777;
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h8888;
        rd_addr2 = 3'd1;
        #1;
        tests_run++;
        if (ready !== 1'b0 || dirty !== 8'h00 || rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
            tests_failed++;
            $display("FAIL clear_enter: ready=%b dirty=%h rd1=%h rd2=%h, want 0 00 0000 0000",
                     ready, dirty, rd_data1, rd_data2);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 8) idle_writes();
            tests_run++;
            if (ready !== (i == 8)) begin
                tests_failed++;
                $display("FAIL clear_ready edge %0d: ready=%b want %b", i, ready, i == 8);
            end
        end
        rd_addr1 = 3'd4; rd_addr2 = 3'd6;
        #1;
        tests_run++;
        if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0 || dirty !== 8'h00) begin
            tests_failed++;
            $display("FAIL clear_after_46: rd4=%h rd6=%h dirty=%h, want 0000 0000 00",
                     rd_data1, rd_data2, dirty);
        end
        rd_addr1 = 3'd1; rd_addr2 = 3'd2;
        #1;
        tests_run++;
        if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
            tests_failed++;
            $display("FAIL clear_after_12: rd1=%h rd2=%h, want 0000 0000", rd_data1, rd_data2);
        end
    endtask

    task automatic test_zero_reg;
        wa_en = 1'b1; wa_addr = 3'd0; wa_data = 16'hFFFF;
        rd_addr1 = 3'd0;
        #1;
        tests_run++;
        if (z_rd_data1 !== 16'h0 || rd_data1 !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL zero_bypass: z_rd1=%h rd1=%h, want 0000 ffff", z_rd_data1, rd_data1);
        end
        tick();
        idle_writes();
        #1;
        tests_run++;
        if (z_rd_data1 !== 16'h0 || z_dirty !== 8'h00 || rd_data1 !== 16'hFFFF || dirty !== 8'h01) begin
            tests_failed++;
            $display("FAIL zero_stored: z_rd1=%h z_dirty=%h rd1=%h dirty=%h, want 0000 00 ffff 01",
                     z_rd_data1, z_dirty, rd_data1, dirty);
        end
        wa_en = 1'b1; wa_addr = 3'd0; wa_data = 16'h1111;
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'h2222;
        tick();
        idle_writes();
        #1;
        tests_run++;
        if (z_wr_conflict !== 1'b1 || z_dirty !== 8'h00 || z_rd_data1 !== 16'h0) begin
            tests_failed++;
            $display("FAIL zero_conflict: z_conflict=%b z_dirty=%h z_rd1=%h, want 1 00 0000",
                     z_wr_conflict, z_dirty, z_rd_data1);
        end
    endtask

    task automatic test_reset_mid_sweep;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (ready !== 1'b0 || dirty !== 8'h00) begin
            tests_failed++;
            $display("FAIL midsweep_reset: ready=%b dirty=%h, want 0 00", ready, dirty);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            tests_run++;
            if (ready !== (i == 8)) begin
                tests_failed++;
                $display("FAIL midsweep_ready edge %0d: ready=%b want %b", i, ready, i == 8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_conflict();
        test_clear_req();
        test_zero_reg();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
